// File: rtl/seq_scan_ctrl.sv
// Serial pattern scanner: shifts a captured word out MSB first and
// counts occurrences of a PAT_W-bit pattern, overlapping or not.
module seq_scan_ctrl #(
  parameter int DATA_W = 8,
  parameter int PAT_W  = 4,
  localparam int CW = $clog2(DATA_W+1),
  localparam int KW = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  input  logic [PAT_W-1:0]  pattern,
  input  logic              overlap,
  output logic              bit_out,
  output logic              busy,
  output logic              done,
  output logic              detected,
  output logic [CW-1:0]     match_count,
  output logic              found,
  output logic [KW-1:0]     first_pos
);

  localparam int VW = $clog2(PAT_W+1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t state, nxt;

  logic [DATA_W-1:0] dat;
  logic [PAT_W-1:0]  pat;
  logic              ovl;
  logic [PAT_W-1:0]  hist;
  logic [VW-1:0]     vcnt;
  logic [KW-1:0]     k;

  logic [KW-1:0]     idx;
  logic              cur;
  logic              last;
  logic [PAT_W-1:0]  hist_n;
  logic [VW-1:0]     vcnt_n;
  logic              hit;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt  = state;
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      IDLE: if (start) nxt = SHIFT;
      SHIFT: begin
        busy = 1'b1;
        if (last) nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        nxt  = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // bit k of the job is dat[DATA_W-1-k]
  assign idx     = KW'(DATA_W-1) - k;
  assign cur     = dat[idx];
  assign last    = (k == KW'(DATA_W-1));
  assign bit_out = busy & cur;

  assign hist_n = {hist[PAT_W-2:0], cur};
  assign vcnt_n = (vcnt == VW'(PAT_W)) ? vcnt : vcnt + VW'(1);
  assign hit    = (vcnt_n == VW'(PAT_W)) && (hist_n == pat);

  always_ff @(posedge clk) begin
    if (reset) begin
      dat         <= '0;
      pat         <= '0;
      ovl         <= 1'b0;
      hist        <= '0;
      vcnt        <= '0;
      k           <= '0;
      detected    <= 1'b0;
      match_count <= '0;
      found       <= 1'b0;
      first_pos   <= '0;
    end else begin
      detected <= 1'b0;
      if (state == IDLE && start) begin
        dat         <= data_in;
        pat         <= pattern;
        ovl         <= overlap;
        hist        <= '0;
        vcnt        <= '0;
        k           <= '0;
        match_count <= '0;
        found       <= 1'b0;
        first_pos   <= '0;
      end else if (state == SHIFT) begin
        k    <= k + KW'(1);
        hist <= hist_n;
        // non-overlapping mode demands PAT_W fresh bits after a hit
        vcnt <= (hit && !ovl) ? '0 : vcnt_n;
        if (hit) begin
          detected    <= 1'b1;
          match_count <= match_count + CW'(1);
          if (!found) begin
            found     <= 1'b1;
            first_pos <= k;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Bench for seq_scan_ctrl: directed table, corner sequences and
// random jobs checked against a window-slicing reference model.
module tb_seq_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, overlap;
  logic [7:0] data_in;
  logic [3:0] pattern;
  logic       bit_out, busy, done, detected, found;
  logic [3:0] match_count;
  logic [2:0] first_pos;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  seq_scan_ctrl #(.DATA_W(8), .PAT_W(4)) dut (
    .clk(clk), .reset(reset), .start(start),
    .data_in(data_in), .pattern(pattern), .overlap(overlap),
    .bit_out(bit_out), .busy(busy), .done(done),
    .detected(detected), .match_count(match_count),
    .found(found), .first_pos(first_pos)
  );

  typedef struct {
    logic [7:0] d;
    logic [3:0] p;
    bit         ov;
    int         cnt;
    bit         fnd;
    int         fpos;
    logic [7:0] mask;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Window ending at bit k holds bits k-3..k, oldest as MSB.
  function automatic void model(input logic [7:0] d, input logic [3:0] p,
                                input bit ov, output logic [7:0] mask,
                                output int cnt, output int fpos);
    int lastm;
    logic [3:0] w;
    mask  = '0;
    cnt   = 0;
    fpos  = 0;
    lastm = -100;
    for (int kk = 3; kk < 8; kk++) begin
      for (int i = 0; i < 4; i++) w[3-i] = d[7-(kk-3+i)];
      if (w == p && (ov || kk - lastm >= 4)) begin
        mask[kk] = 1'b1;
        if (cnt == 0) fpos = kk;
        cnt++;
        lastm = kk;
      end
    end
  endfunction

  // Entered at a negedge in IDLE; leaves at the negedge of cycle T+10.
  task automatic run_job(input string nm, input logic [7:0] d,
                         input logic [3:0] p, input bit ov,
                         input int cnt, input bit fnd, input int fpos,
                         input logic [7:0] mask, input bit poke);
    logic [8:0] det_a, det_e, bsy_a, bsy_e, dn_a, dn_e, bo_a, bo_e;
    data_in = d;
    pattern = p;
    overlap = ov;
    start   = 1'b1;
    for (int j = 1; j <= 9; j++) begin
      @(negedge clk);
      if (j == 1) begin
        start   = 1'b0;
        data_in = ~d;
        pattern = ~p;
        overlap = ~ov;
      end
      if (poke) start = (j == 3);
      det_a[j-1] = detected;
      bsy_a[j-1] = busy;
      dn_a[j-1]  = done;
      bo_a[j-1]  = bit_out;
      det_e[j-1] = (j >= 2) ? mask[j-2] : 1'b0;
      bsy_e[j-1] = (j <= 8);
      dn_e[j-1]  = (j == 9);
      bo_e[j-1]  = (j <= 8) ? d[8-j] : 1'b0;
    end
    start = 1'b0;
    @(negedge clk);
    chk({nm, " detected seq"}, 32'(det_a), 32'(det_e));
    chk({nm, " busy seq"}, 32'(bsy_a), 32'(bsy_e));
    chk({nm, " done seq"}, 32'(dn_a), 32'(dn_e));
    chk({nm, " bit_out seq"}, 32'(bo_a), 32'(bo_e));
    chk({nm, " idle outs"}, {busy, done, detected, bit_out}, 4'b0);
    chk({nm, " match_count"}, 32'(match_count), 32'(cnt));
    chk({nm, " found"}, 32'(found), 32'(fnd));
    chk({nm, " first_pos"}, 32'(first_pos), 32'(fpos));
  endtask

  vec_t tbl[7];

  initial begin
    logic [7:0] m;
    logic [7:0] rd;
    logic [3:0] rp;
    bit rov;
    int c, f;
    bit any_done;

    tbl[0] = '{8'hB6, 4'b1011, 1'b1, 2, 1'b1, 3, 8'b0100_1000};
    tbl[1] = '{8'hB6, 4'b1011, 1'b0, 1, 1'b1, 3, 8'b0000_1000};
    tbl[2] = '{8'hB2, 4'b1011, 1'b1, 1, 1'b1, 3, 8'b0000_1000};
    tbl[3] = '{8'h00, 4'b1011, 1'b1, 0, 1'b0, 0, 8'b0000_0000};
    tbl[4] = '{8'h00, 4'b0000, 1'b1, 5, 1'b1, 3, 8'b1111_1000};
    tbl[5] = '{8'h00, 4'b0000, 1'b0, 2, 1'b1, 3, 8'b1000_1000};
    tbl[6] = '{8'h3B, 4'b1011, 1'b0, 1, 1'b1, 7, 8'b1000_0000};

    reset = 1'b1; start = 1'b1; overlap = 1'b0;
    data_in = 8'hFF; pattern = 4'hF;
    repeat (3) @(negedge clk);
    chk("reset outs", {busy, done, detected, bit_out, found},
        5'b0);
    chk("reset results", {match_count, first_pos}, 7'b0);
    reset = 1'b0; start = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++)
      run_job($sformatf("vec%0d", i), tbl[i].d, tbl[i].p, tbl[i].ov,
              tbl[i].cnt, tbl[i].fnd, tbl[i].fpos, tbl[i].mask, 1'b0);

    // start mid-job ignored, then back-to-back accept
    run_job("poke", 8'hB6, 4'b1011, 1'b1, 2, 1'b1, 3,
            8'b0100_1000, 1'b1);
    run_job("b2b", 8'hB2, 4'b1011, 1'b1, 1, 1'b1, 3,
            8'b0000_1000, 1'b0);

    // reset during cycle T+4
    data_in = 8'hB6; pattern = 4'b1011; overlap = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort outs", {busy, done, detected, bit_out, found}, 5'b0);
    chk("abort results", {match_count, first_pos}, 7'b0);
    any_done = 1'b0;
    for (int j = 0; j < 8; j++) begin
      if (done || busy) any_done = 1'b1;
      @(negedge clk);
    end
    chk("abort no done", 32'(any_done), 32'd0);
    run_job("post abort", 8'hB6, 4'b1011, 1'b1, 2, 1'b1, 3,
            8'b0100_1000, 1'b0);

    for (int i = 0; i < 40; i++) begin
      rd  = 8'($urandom);
      rp  = 4'($urandom);
      rov = 1'($urandom);
      if (i % 3 == 0) rp = rd[5:2];
      model(rd, rp, rov, m, c, f);
      run_job($sformatf("rnd%0d", i), rd, rp, rov, c, c > 0, f, m,
              1'($urandom));
      if (i % 4 == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seq_scan_ctrl.md
SEQ_SCAN_CTRL -- requirements
Module: seq_scan_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8, which sets the number of bits scanned per job (range 4..32).
REQ-002 SHALL have parameter PAT_W, default 4, which sets the pattern length in bits (range 2..DATA_W).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: job request, sampled only in IDLE.
REQ-006 SHALL have port data_in, input, DATA_W bits: word to scan, MSB first.
REQ-007 SHALL have port pattern, input, PAT_W bits: target sequence, MSB is the oldest bit.
REQ-008 SHALL have port overlap, input, 1 bit: 1 = overlapping matches counted; 0 = the window restarts after each match.
REQ-009 SHALL have port bit_out, output, 1 bit: the serial bit currently being scanned.
REQ-010 SHALL have port busy, output, 1 bit: high in SHIFT.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse in DONE.
REQ-012 SHALL have port detected, output, 1 bit: one-cycle pulse per match.
REQ-013 SHALL have port match_count, output, CW = $clog2(DATA_W+1) bits: matches in the last job.
REQ-014 SHALL have port found, output, 1 bit: at least one match in the last job.
REQ-015 SHALL have port first_pos, output, $clog2(DATA_W) bits: index k of the final bit of the first match.

Function
REQ-016 SHALL implement FSM states IDLE, SHIFT, DONE with these transitions: IDLE->SHIFT on start; SHIFT->DONE after bit k=DATA_W-1; DONE->IDLE unconditionally.
REQ-017 SHALL, at the edge T where start=1 in IDLE, capture data_in, pattern and overlap, and clear history, valid count, match_count, found and first_pos.
REQ-018 SHALL ignore start in SHIFT and DONE; captured operands SHALL NOT change mid-job.
REQ-019 SHALL occupy SHIFT for cycles T+1..T+DATA_W, with k = cycle-T-1, and drive bit_out = captured[DATA_W-1-k]; bit_out SHALL be 0 outside SHIFT.
REQ-020 SHALL, at the end of each SHIFT cycle, shift bit k into the PAT_W-bit history and increment the valid count, saturating at PAT_W.
REQ-021 SHALL declare a match when the updated valid count equals PAT_W and the updated history equals pattern.
REQ-022 SHALL, on a match, assert detected in cycle T+k+2 for exactly one cycle and increment match_count; the match for k=DATA_W-1 lands in DONE.
REQ-023 SHALL, on the first match of a job, set found=1 and first_pos=k; later matches SHALL NOT change first_pos.
REQ-024 SHALL, on a match with overlap=0, reset the valid count to 0 so that the next match needs PAT_W fresh bits; with overlap=1 the history is retained.
REQ-025 SHALL hold busy=1 exactly during SHIFT and done=1 exactly during DONE (cycle T+DATA_W+1).
REQ-026 SHALL never wrap match_count, since CW holds DATA_W.
REQ-027 SHALL hold match_count, found and first_pos from DONE until the next accepted start.
REQ-028 SHALL accept start asserted in the first IDLE cycle after DONE, giving back-to-back jobs with one idle cycle between them.

Reset
REQ-029 SHALL, while reset=1 at an edge, go to IDLE and clear busy, done, detected, bit_out, match_count, found, first_pos, history and valid count, taking priority over start.
REQ-030 SHALL, on reset mid-SHIFT or in DONE, abort the job, produce no done pulse, and give all outputs 0 from the next cycle.

Verification
REQ-031 SHALL cover: pattern=4'b1011, overlap=1, data_in=8'hB6 -> detected at T+5 and T+8; done at T+9; match_count=2; found=1; first_pos=3.
REQ-032 SHALL cover: the same job with overlap=0 -> detected only at T+5; match_count=1; first_pos=3.
REQ-033 SHALL cover: pattern=4'b1011, data_in=8'hB2 (bits 1,0,1,1,0,0,1,0) -> a single detected at T+5; match_count=1; bit_out sequence matches the data bits over T+1..T+8.
REQ-034 SHALL cover: data_in=8'h00, pattern=4'b1011 -> no detected pulse; match_count=0; found=0; first_pos=0; done at T+9.
REQ-035 SHALL cover: start pulsed at T+3 during a job -> ignored, with results identical to REQ-031; then start in the first IDLE cycle -> new job accepted.
REQ-036 SHALL cover: reset asserted at T+4 of a job -> IDLE with all outputs 0 at T+5, no done pulse, and a subsequent job completes normally.
